// File: rtl/hansen_uart_tx.sv
// hansen_uart_tx: byte-wide transmit FIFO feeding an 8N1 UART serializer.
// Bytes written while the FIFO has room are queued. Queued bytes are sent
// back-to-back with no idle gap. tx idles high and is driven from a flop.
module hansen_uart_tx #(
   parameter int CLKS_PER_BIT = 868,   // clk cycles per serial bit
   parameter int FIFO_DEPTH   = 16     // power of two, at least 2
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   output logic       full,
   output logic       empty,
   output logic       busy,
   output logic       overflow,
   output logic       tx
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int PW = AW + 1;
   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] BIT_RELOAD = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = CW'(1);
   localparam logic [PW-1:0] PTR_ZERO   = {PW{1'b0}};
   localparam logic [PW-1:0] PTR_ONE    = PW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } state_t;

   // FIFO storage and pointers. Pointers carry one extra wrap bit, so that
   // full and empty can be told apart when the index bits are equal.
   logic [7:0]    mem_r [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_r;
   logic [PW-1:0] rd_ptr_r;
   logic          empty_s;
   logic          full_s;
   logic          push_s;
   logic          pop_s;

   // Serializer state
   state_t        state_r;
   state_t        state_next_s;
   logic [CW-1:0] cnt_r;
   logic [CW-1:0] cnt_next_s;
   logic [2:0]    idx_r;
   logic [2:0]    idx_next_s;
   logic [7:0]    shift_r;
   logic [7:0]    shift_next_s;
   logic          tx_r;
   logic          tx_next_s;
   logic          busy_r;
   logic          overflow_r;

   assign empty_s = (wr_ptr_r == rd_ptr_r);
   assign full_s  = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                    (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
   // full is the pre-edge value. A write against a full FIFO is dropped even
   // if a pop happens on the same edge.
   assign push_s  = wr_en & ~full_s;

   assign full     = full_s;
   assign empty    = empty_s;
   assign busy     = busy_r;
   assign overflow = overflow_r;
   assign tx       = tx_r;

   // FIFO storage write; contents need no reset because the pointers gate reads
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= wr_data;
      end
   end

   // FIFO pointers and sticky overflow flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         overflow_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + PTR_ONE;
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PTR_ONE;
         end
         if (wr_en && full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

   // Serializer next-state: bit timing, shifting, FIFO pop and next tx level
   always_comb begin
      state_next_s = state_r;
      cnt_next_s   = cnt_r;
      idx_next_s   = idx_r;
      shift_next_s = shift_r;
      tx_next_s    = tx_r;
      pop_s        = 1'b0;
      case (state_r)
         IDLE: begin
            // empty_s comes from registered pointers, so a byte written at
            // this edge is popped one edge later.
            if (!empty_s) begin
               pop_s        = 1'b1;
               shift_next_s = mem_r[rd_ptr_r[AW-1:0]];
               cnt_next_s   = BIT_RELOAD;
               tx_next_s    = 1'b0;
               state_next_s = START;
            end else begin
               tx_next_s    = 1'b1;
            end
         end
         START: begin
            if (cnt_r == CNT_ZERO) begin
               cnt_next_s   = BIT_RELOAD;
               idx_next_s   = 3'd0;
               tx_next_s    = shift_r[0];
               state_next_s = DATA;
            end else begin
               cnt_next_s   = cnt_r - CNT_ONE;
            end
         end
         DATA: begin
            if (cnt_r == CNT_ZERO) begin
               cnt_next_s = BIT_RELOAD;
               if (idx_r == 3'd7) begin
                  tx_next_s    = 1'b1;
                  state_next_s = STOP;
               end else begin
                  shift_next_s = {1'b0, shift_r[7:1]};
                  idx_next_s   = idx_r + 3'd1;
                  tx_next_s    = shift_r[1];
               end
            end else begin
               cnt_next_s = cnt_r - CNT_ONE;
            end
         end
         STOP: begin
            if (cnt_r == CNT_ZERO) begin
               // Chain straight into the next start bit when data is waiting
               if (!empty_s) begin
                  pop_s        = 1'b1;
                  shift_next_s = mem_r[rd_ptr_r[AW-1:0]];
                  cnt_next_s   = BIT_RELOAD;
                  tx_next_s    = 1'b0;
                  state_next_s = START;
               end else begin
                  cnt_next_s   = CNT_ZERO;
                  tx_next_s    = 1'b1;
                  state_next_s = IDLE;
               end
            end else begin
               cnt_next_s = cnt_r - CNT_ONE;
            end
         end
         default: begin
            cnt_next_s   = CNT_ZERO;
            tx_next_s    = 1'b1;
            state_next_s = IDLE;
         end
      endcase
   end

   // Serializer registers, including the registered tx and busy outputs
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r <= IDLE;
         cnt_r   <= CNT_ZERO;
         idx_r   <= 3'd0;
         shift_r <= 8'd0;
         tx_r    <= 1'b1;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         cnt_r   <= cnt_next_s;
         idx_r   <= idx_next_s;
         shift_r <= shift_next_s;
         tx_r    <= tx_next_s;
         busy_r  <= (state_next_s != IDLE);
      end
   end

endmodule

// File: tb/tb_hansen_uart_tx.sv
// Bench for hansen_uart_tx. The stimulus pushes every byte it expects on the
// line into a queue. A line monitor decodes each 8N1 frame from tx and
// compares it against the head of the queue.
module tb_hansen_uart_tx;

   localparam int C = 4;   // CLKS_PER_BIT
   localparam int D = 4;   // FIFO_DEPTH

   logic       clk = 1'b0;
   logic       reset_n;
   logic       wr_en;
   logic [7:0] wr_data;
   logic       full;
   logic       empty;
   logic       busy;
   logic       overflow;
   logic       tx;

   int         vectors     = 0;
   int         miscompares = 0;
   int         cyc         = 0;
   logic [7:0] exp_q[$];
   int         frame_starts[$];

   hansen_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .full     (full),
      .empty    (empty),
      .busy     (busy),
      .overflow (overflow),
      .tx       (tx)
   );

   // 100 MHz clock
   always #5 clk = ~clk;

   // cycle counter used to time frame starts
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vectors++;
      if (act !== req) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // write one byte at the next edge; queue it as expected output if it should be accepted
   task automatic wr(input logic [7:0] d, input logic accept);
      wr_en   = 1'b1;
      wr_data = d;
      @(posedge clk); #1;
      wr_en   = 1'b0;
      wr_data = 8'($urandom);
      if (accept) exp_q.push_back(d);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy !== 1'b0) && n < 5000) begin
         @(posedge clk); #1;
         n++;
      end
      check(name, 32'(n < 5000), 32'd1);
   endtask

   // line monitor: decodes frames sampled on the falling edge
   initial begin : monitor
      logic [9:0] got;
      logic       stable;
      logic       aborted;
      logic       cur;
      logic [7:0] e;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && tx === 1'b0) begin
            frame_starts.push_back(cyc);
            got     = 10'd0;
            stable  = 1'b1;
            aborted = 1'b0;
            cur     = 1'b0;
            for (int k = 0; k < 10*C; k++) begin
               if (k > 0) @(negedge clk);
               if (reset_n !== 1'b1) begin
                  aborted = 1'b1;
                  break;
               end
               if (k % C == 0) cur = tx;
               else if (tx !== cur) stable = 1'b0;
               if (k % C == C/2) got[k/C] = tx;
            end
            if (!aborted) begin
               if (exp_q.size() == 0) begin
                  vectors++;
                  miscompares++;
                  $display("FAIL unexpected_frame: got frame %b, required no frame", got);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_bits", 32'(got), 32'({1'b1, e, 1'b0}));
                  check("bit_width", 32'(stable), 32'd1);
               end
            end
         end
      end
   end

   // watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got no finish, required finish before 500000 ns");
      $fatal(1, "watchdog expired");
   end

   // directed stimulus
   initial begin : stim
      int n;
      int nf;
      int gap;
      reset_n = 1'b0;
      wr_en   = 1'b0;
      wr_data = 8'h00;
      @(posedge clk); #1;
      check("rst_tx", 32'(tx), 32'd1);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_overflow", 32'(overflow), 32'd0);
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (2) @(posedge clk); #1;

      // single byte 0xA5: tx falls one edge after the write, busy for 40 cycles
      wr(8'hA5, 1'b1);
      check("lat_tx_hold", 32'(tx), 32'd1);
      check("lat_empty_after_write", 32'(empty), 32'd0);
      check("lat_busy_before_pop", 32'(busy), 32'd0);
      @(posedge clk); #1;
      check("lat_tx_fall", 32'(tx), 32'd0);
      check("lat_busy_rise", 32'(busy), 32'd1);
      check("lat_empty_after_pop", 32'(empty), 32'd1);
      n = 0;
      while (busy === 1'b1 && n < 100) begin
         n++;
         @(posedge clk); #1;
      end
      check("busy_cycles", 32'(n), 32'd40);
      check("single_empty_end", 32'(empty), 32'd1);
      check("single_tx_end", 32'(tx), 32'd1);
      wait_drain("single_drain");

      // back-to-back 0x00, 0xFF: frames 40 cycles apart with no gap
      repeat (3) @(posedge clk); #1;
      nf = frame_starts.size();
      wr(8'h00, 1'b1);
      wr(8'hFF, 1'b1);
      wait_drain("b2b_drain");
      check("b2b_frames", 32'(frame_starts.size() - nf), 32'd2);
      gap = (frame_starts.size() >= nf + 2) ? frame_starts[nf+1] - frame_starts[nf] : -1;
      check("b2b_gap", 32'(gap), 32'd40);
      check("b2b_tx_idle", 32'(tx), 32'd1);

      // overflow: 6 consecutive writes from idle, first pops after one cycle, 6th dropped
      repeat (3) @(posedge clk); #1;
      nf = frame_starts.size();
      wr(8'h31, 1'b1);
      wr(8'h32, 1'b1);
      wr(8'h33, 1'b1);
      wr(8'h34, 1'b1);
      wr(8'h35, 1'b1);
      check("ovf_full_at_depth", 32'(full), 32'd1);
      check("ovf_not_yet", 32'(overflow), 32'd0);
      wr(8'h36, 1'b0);
      check("ovf_full_after_drop", 32'(full), 32'd1);
      check("ovf_set", 32'(overflow), 32'd1);
      wait_drain("ovf_drain");
      check("ovf_frames", 32'(frame_starts.size() - nf), 32'd5);
      check("ovf_sticky", 32'(overflow), 32'd1);
      check("ovf_empty_end", 32'(empty), 32'd1);

      // simultaneous write and pop with count = FIFO_DEPTH-1
      repeat (3) @(posedge clk); #1;
      wr(8'h41, 1'b1);           // edge N, popped at N+1
      wr(8'h42, 1'b1);           // N+1, count stays 1
      wr(8'h43, 1'b1);           // N+2, count 2
      wr(8'h44, 1'b1);           // N+3, count 3
      check("sim_pre_count3_full", 32'(full), 32'd0);
      repeat (37) @(posedge clk); #1;   // now after edge N+40
      check("sim_pre_full", 32'(full), 32'd0);
      wr(8'h45, 1'b1);           // N+41: write and STOP->START pop together
      check("sim_full_unchanged", 32'(full), 32'd0);
      check("sim_busy_no_gap", 32'(busy), 32'd1);
      check("sim_tx_start_no_gap", 32'(tx), 32'd0);
      wr(8'h46, 1'b1);           // N+42: count 3 -> 4
      check("sim_full_after_extra", 32'(full), 32'd1);
      wait_drain("sim_drain");

      // wrap-around: 48 incrementing bytes throttled on full
      repeat (3) @(posedge clk); #1;
      nf = frame_starts.size();
      for (int i = 0; i < 48; i++) begin
         n = 0;
         while (full === 1'b1 && n < 200) begin
            @(posedge clk); #1;
            n++;
         end
         wr(8'(i), 1'b1);
      end
      wait_drain("wrap_drain");
      check("wrap_frames", 32'(frame_starts.size() - nf), 32'd48);

      // reset during data bit 3 of 0x3C with two bytes queued
      repeat (3) @(posedge clk); #1;
      nf = frame_starts.size();
      wr(8'h3C, 1'b1);           // edge N, popped at N+1
      wr(8'h11, 1'b1);
      wr(8'h22, 1'b1);           // now after N+2
      repeat (16) @(posedge clk); #1;   // after N+18: inside data bit 3
      check("rst_mid_bit3", 32'(tx), 32'd1);
      check("rst_mid_busy_before", 32'(busy), 32'd1);
      #2;
      reset_n = 1'b0;
      #1;
      check("rst_mid_tx", 32'(tx), 32'd1);
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_empty", 32'(empty), 32'd1);
      check("rst_mid_overflow", 32'(overflow), 32'd0);
      exp_q.delete();
      repeat (2) @(posedge clk); #1;
      reset_n = 1'b1;
      repeat (100) @(posedge clk); #1;
      check("rst_no_new_frame", 32'(frame_starts.size() - nf), 32'd1);
      check("rst_after_tx", 32'(tx), 32'd1);
      check("rst_after_busy", 32'(busy), 32'd0);
      check("rst_after_empty", 32'(empty), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
